// File: rtl/rnd_range_sampler.sv
// Bounded uniform sampler. Each request masks the free-running generator word
// down to the smallest power-of-two range covering [0, N) and rejects any
// candidate that is >= N. A request gives up after MAX_TRIES rejections.
module rnd_range_sampler #(
    parameter int MAX_TRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rnd_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_bound,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_value,
    output logic [4:0]  out_tries,
    output logic        out_err,
    output logic [31:0] rej_count
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // SEARCH | one masked candidate tested per cycle
    // DONE   | result held until the consumer takes it
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [4:0] MAX_T = 5'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [31:0] bound_q, bound_d;
    logic [31:0] mask_q, mask_d;
    logic [4:0]  tries_q, tries_d;
    logic [31:0] out_value_q, out_value_d;
    logic [4:0]  out_tries_q, out_tries_d;
    logic        out_err_q, out_err_d;
    logic [31:0] rej_count_q, rej_count_d;

    logic [31:0] mask_new;
    logic [31:0] cand;
    logic        accept;
    logic [4:0]  tries_inc;

    // Smear the MSB of (N-1) down to bit 0; N=0 wraps to all ones.
    always_comb begin
        mask_new = req_bound - 32'd1;
        mask_new = mask_new | (mask_new >> 1);
        mask_new = mask_new | (mask_new >> 2);
        mask_new = mask_new | (mask_new >> 4);
        mask_new = mask_new | (mask_new >> 8);
        mask_new = mask_new | (mask_new >> 16);
    end

    assign cand      = rnd_in & mask_q;
    assign accept    = (bound_q == 32'd0) || (cand < bound_q);
    assign tries_inc = tries_q + 5'd1;

    // Next-state and datapath updates for the request/search/result sequence.
    always_comb begin
        state_d     = state_q;
        bound_d     = bound_q;
        mask_d      = mask_q;
        tries_d     = tries_q;
        out_value_d = out_value_q;
        out_tries_d = out_tries_q;
        out_err_d   = out_err_q;
        rej_count_d = rej_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bound_d = req_bound;
                    mask_d  = mask_new;
                    tries_d = 5'd0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (accept) begin
                    out_value_d = cand;
                    out_err_d   = 1'b0;
                    out_tries_d = tries_q;
                    state_d     = DONE;
                end else begin
                    tries_d = tries_inc;
                    if (rej_count_q != 32'hFFFF_FFFF) begin
                        rej_count_d = rej_count_q + 32'd1;
                    end
                    if (tries_inc == MAX_T) begin
                        out_value_d = 32'd0;
                        out_err_d   = 1'b1;
                        out_tries_d = MAX_T;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bound_q     <= 32'd0;
            mask_q      <= 32'd0;
            tries_q     <= 5'd0;
            out_value_q <= 32'd0;
            out_tries_q <= 5'd0;
            out_err_q   <= 1'b0;
            rej_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            bound_q     <= bound_d;
            mask_q      <= mask_d;
            tries_q     <= tries_d;
            out_value_q <= out_value_d;
            out_tries_q <= out_tries_d;
            out_err_q   <= out_err_d;
            rej_count_q <= rej_count_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_value = out_value_q;
    assign out_tries = out_tries_q;
    assign out_err   = out_err_q;
    assign rej_count = rej_count_q;

endmodule

// File: tb/tb_rnd_range_sampler.sv
// Directed bench for rnd_range_sampler. Inputs change 1 ns after a rising
// edge and outputs are checked at that same point, away from the edge.
module tb_rnd_range_sampler;

    logic        clk;
    logic        rst;
    logic [31:0] rnd_in;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_bound;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [4:0]  out_tries;
    logic        out_err;
    logic [31:0] rej_count;

    int n_vec;
    int n_err;

    rnd_range_sampler #(.MAX_TRIES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_in    (rnd_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bound (req_bound),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_tries (out_tries),
        .out_err   (out_err),
        .rej_count (rej_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request in IDLE; returns in the first SEARCH cycle.
    task automatic issue(input logic [31:0] n);
        req_bound = n;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: req_ready=%b out_valid=%b want 1/0", req_ready, out_valid);
        end
        n_vec++;
        if (out_value !== 32'd0 || out_tries !== 5'd0 || out_err !== 1'b0 || rej_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_out: value=%h tries=%0d err=%b rej=%0d want all 0",
                     out_value, out_tries, out_err, rej_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_n1();
        issue(32'd1);
        rnd_in = 32'hFFFF_FFFF;
        n_vec++;
        if (out_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL n1_search: out_valid=%b req_ready=%b want 0/0", out_valid, req_ready);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_value !== 32'd0 || out_tries !== 5'd0 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL n1_done: valid=%b value=%h tries=%0d err=%b want 1/0/0/0",
                     out_valid, out_value, out_tries, out_err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL n1_return: req_ready=%b out_valid=%b want 1/0", req_ready, out_valid);
        end
    endtask

    task automatic test_full_range();
        issue(32'd0);
        rnd_in = 32'hDEAD_BEEF;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_value !== 32'hDEAD_BEEF || out_tries !== 5'd0 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL full_range: valid=%b value=%h tries=%0d err=%b want 1/deadbeef/0/0",
                     out_valid, out_value, out_tries, out_err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reject();
        issue(32'd5);
        rnd_in = 32'h0000_000F;
        step();
        rnd_in = 32'h0000_0006;
        n_vec++;
        if (out_valid !== 1'b0 || rej_count !== 32'd1) begin
            n_err++;
            $display("FAIL reject_first: valid=%b rej=%0d want 0/1", out_valid, rej_count);
        end
        step();
        rnd_in = 32'h0000_0003;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_value !== 32'd3 || out_tries !== 5'd2 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL reject_done: valid=%b value=%0d tries=%0d err=%b want 1/3/2/0",
                     out_valid, out_value, out_tries, out_err);
        end
        n_vec++;
        if (rej_count !== 32'd2) begin
            n_err++;
            $display("FAIL reject_count: rej=%0d want 2", rej_count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_max_tries();
        issue(32'd5);
        rnd_in = 32'h0000_0007;
        for (int i = 0; i < 15; i++) step();
        n_vec++;
        if (out_valid !== 1'b0 || rej_count !== 32'd17) begin
            n_err++;
            $display("FAIL max_pre: valid=%b rej=%0d want 0/17", out_valid, rej_count);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_value !== 32'd0 || out_tries !== 5'd16) begin
            n_err++;
            $display("FAIL max_done: valid=%b err=%b value=%h tries=%0d want 1/1/0/16",
                     out_valid, out_err, out_value, out_tries);
        end
        n_vec++;
        if (rej_count !== 32'd18) begin
            n_err++;
            $display("FAIL max_count: rej=%0d want 18", rej_count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_pow2();
        issue(32'd16);
        rnd_in = 32'hFFFF_FFF9;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_value !== 32'd9 || out_tries !== 5'd0) begin
            n_err++;
            $display("FAIL pow2_16: valid=%b value=%h tries=%0d want 1/9/0", out_valid, out_value, out_tries);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        issue(32'h8000_0000);
        rnd_in = 32'hFFFF_FFFF;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_value !== 32'h7FFF_FFFF || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL pow2_31: valid=%b value=%h err=%b want 1/7fffffff/0", out_valid, out_value, out_err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        issue(32'd2);
        rnd_in = 32'h0000_0001;
        step();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_bound = 32'd0;
            rnd_in    = 32'h1234_5670 + 32'(i);
            step();
            n_vec++;
            if (out_valid !== 1'b1 || req_ready !== 1'b0 || out_value !== 32'd1 ||
                out_tries !== 5'd0 || out_err !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: valid=%b req_ready=%b value=%h tries=%0d err=%b want 1/0/1/0/0",
                         i, out_valid, req_ready, out_value, out_tries, out_err);
            end
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: req_ready=%b out_valid=%b want 1/0", req_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        req_bound = 32'd3;
        req_valid = 1'b1;
        out_ready = 1'b1;
        rnd_in    = 32'h0000_0002;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_vec++;
            if (out_valid !== (i % 3 == 2) || req_ready !== (i % 3 == 0) ||
                ((i % 3 == 2) && out_value !== 32'd2)) begin
                n_err++;
                $display("FAIL b2b_%0d: valid=%b req_ready=%b value=%h want %b/%b/2",
                         i, out_valid, req_ready, out_value, (i % 3 == 2), (i % 3 == 0));
            end
        end
        req_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(32'd5);
        rnd_in = 32'h0000_0007;
        step();
        n_vec++;
        if (rej_count !== 32'd19 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_pre: rej=%0d valid=%b want 19/0", rej_count, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || rej_count !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b req_ready=%b rej=%0d want 0/1/0",
                     out_valid, req_ready, rej_count);
        end
        step();
        rst = 1'b0;
        step();
        issue(32'd1);
        rnd_in = 32'hA5A5_A5A5;
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_value !== 32'd0 || out_tries !== 5'd0 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_after: valid=%b value=%h tries=%0d err=%b want 1/0/0/0",
                     out_valid, out_value, out_tries, out_err);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        rnd_in    = 32'd0;
        req_valid = 1'b0;
        req_bound = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_n1();
        test_full_range();
        test_reject();
        test_max_tries();
        test_pow2();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rnd_range_sampler.md
RND_RANGE_SAMPLER -- requirements
Module: rnd_range_sampler

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 16, the maximum number of rejected candidates per request (legal range 1..31).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rnd_in, input, 32, the free-running generator state word; a new value arrives every cycle.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_bound, input, 32, exclusive upper bound N; 0 means the full 2^32 range.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port out_value, output, 32, sampled value in [0, N).
REQ-011 SHALL have port out_tries, output, 5, rejected candidates for this result.
REQ-012 SHALL have port out_err, output, 1, MAX_TRIES exhausted without acceptance.
REQ-013 SHALL have port rej_count, output, 32, cumulative rejected candidates.

Function
REQ-014 SHALL implement states IDLE, SEARCH and DONE; req_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 In IDLE, req_valid&req_ready SHALL latch req_bound, compute mask = all-ones from the MSB of (N-1) down to bit 0, clear the try counter, and go to SEARCH.
REQ-016 Mask rules: N=1 gives mask 0; N=0 gives mask 0xFFFFFFFF; N=2^k gives mask 2^k-1.
REQ-017 In SEARCH, each cycle candidate = rnd_in & mask; accept if N==0 or candidate < N (unsigned 32-bit compare).
REQ-018 On accept: out_value <= candidate, out_err <= 0, out_tries <= try count, go to DONE.
REQ-019 On reject: try count +1 and rej_count +1; if the incremented count equals MAX_TRIES: out_value <= 0, out_err <= 1, out_tries <= MAX_TRIES, go to DONE; otherwise stay in SEARCH.
REQ-020 Minimum latency: request accepted at edge T, SEARCH samples rnd_in in the cycle after T, out_valid high after edge T+2.
REQ-021 In DONE, out_value, out_tries and out_err SHALL hold stable until out_valid&out_ready; that edge returns to IDLE, so req_ready is high in the following cycle.
REQ-022 req_bound and req_valid SHALL be ignored outside IDLE; rnd_in SHALL be ignored outside SEARCH.
REQ-023 rej_count SHALL saturate at 0xFFFFFFFF and clear only on reset.
REQ-024 Peak throughput SHALL be one result per 3 cycles; no request is buffered while busy.

Reset
REQ-025 While rst is high: state=IDLE, req_ready=1, out_valid=0, out_value=0, out_tries=0, out_err=0, rej_count=0, latched bound/mask/try count=0.
REQ-026 rst asserted in SEARCH or DONE SHALL take effect immediately (asynchronous), discarding the pending request and result.

Verification
REQ-027 N=1, any rnd_in -> out_value=0, out_tries=0, out_err=0, out_valid high 2 cycles after accept.
REQ-028 N=0, rnd_in=0xDEADBEEF in the SEARCH cycle -> out_value=0xDEADBEEF, out_tries=0.
REQ-029 N=5 (mask 7), rnd_in over SEARCH cycles = 0x0000000F, 0x00000006, 0x00000003 -> out_value=3, out_tries=2, rej_count increases by 2.
REQ-030 N=5, rnd_in held at 0x00000007 -> after 16 SEARCH cycles out_err=1, out_value=0, out_tries=16, rej_count=16.
REQ-031 out_ready low for 4 cycles in DONE -> out_valid and outputs stable, req_ready=0, a new req_valid is not accepted; after the handshake, req_ready=1 next cycle.
REQ-032 rst pulsed mid-SEARCH -> out_valid=0 and req_ready=1 immediately, rej_count=0; a subsequent N=1 request completes normally.
